// File: rtl/siacore_sched_if.sv
// Job, core and result channels of the siacore job scheduler.
// The slave side is the scheduler. The master side is whoever supplies jobs, models the core and sinks results.
interface siacore_sched_if #(
  parameter int ID_W = 8
);
  logic            job_valid;
  logic            job_ready;
  logic [639:0]    job_work;
  logic [63:0]     job_target;
  logic [ID_W-1:0] job_id;
  logic [639:0]    core_work;
  logic [63:0]     core_target;
  logic            core_valid;
  logic            core_busy;
  logic            core_found;
  logic [31:0]     core_nonce;
  logic            flush;
  logic            res_valid;
  logic            res_ready;
  logic [ID_W-1:0] res_id;
  logic [31:0]     res_nonce;
  logic [1:0]      res_status;

  modport slave (
    input  job_valid, job_work, job_target, job_id,
    input  core_busy, core_found, core_nonce, flush, res_ready,
    output job_ready, core_work, core_target, core_valid,
    output res_valid, res_id, res_nonce, res_status
  );

  modport master (
    output job_valid, job_work, job_target, job_id,
    output core_busy, core_found, core_nonce, flush, res_ready,
    input  job_ready, core_work, core_target, core_valid,
    input  res_valid, res_id, res_nonce, res_status
  );
endinterface

// File: rtl/siacore_sched.sv
// Single-job scheduler in front of a siacore hasher. It issues one job, watches for a found nonce,
// a flush or a timeout, and reports exactly one result per accepted job.
module siacore_sched #(
  parameter logic [31:0] TIMEOUT = 32'd1000000,
  parameter int          ID_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  siacore_sched_if.slave bus,
  output logic [31:0]    stat_jobs,
  output logic [31:0]    stat_found
);
  typedef enum logic [2:0] {IDLE, ISSUE, RUN, DRAIN, REPORT} state_t;
  typedef enum logic [1:0] {ST_FOUND = 2'd0, ST_TIMEOUT = 2'd1, ST_ABORT = 2'd2} status_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     nonce;
    status_t         status;
  } res_t;

  localparam logic [31:0] TLAST = TIMEOUT - 32'd1;

  state_t       state, state_nx;
  logic [639:0] work_q;
  logic [63:0]  target_q;
  logic [31:0]  cnt;
  res_t         res_q;
  logic         accept, found_ev, abort_ev, tmo_ev;

  assign bus.core_work   = work_q;
  assign bus.core_target = target_q;
  assign bus.res_id      = res_q.id;
  assign bus.res_nonce   = res_q.nonce;
  assign bus.res_status  = res_q.status;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // In ISSUE and RUN the events are tested in priority order: found, then flush, then timeout.
  always_comb begin
    state_nx       = state;
    accept         = 1'b0;
    found_ev       = 1'b0;
    abort_ev       = 1'b0;
    tmo_ev         = 1'b0;
    bus.job_ready  = (state == IDLE);
    bus.core_valid = (state == ISSUE);
    bus.res_valid  = (state == REPORT);
    case (state)
      IDLE: if (bus.job_valid) begin
        accept   = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE, RUN: begin
        if (bus.core_found) begin
          found_ev = 1'b1;
          state_nx = REPORT;
        end else if (bus.flush) begin
          abort_ev = 1'b1;
          state_nx = DRAIN;
        end else if (cnt == TLAST) begin
          tmo_ev   = 1'b1;
          state_nx = DRAIN;
        end else if (state == ISSUE && bus.core_busy) begin
          state_nx = RUN;
        end
      end
      DRAIN:   if (!bus.core_busy) state_nx = REPORT;
      REPORT:  if (bus.res_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The result id is taken at accept, so it stays stable through REPORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q     <= '0;
      target_q   <= '0;
      cnt        <= '0;
      res_q      <= '0;
      stat_jobs  <= '0;
      stat_found <= '0;
    end else begin
      if (accept) begin
        work_q    <= bus.job_work;
        target_q  <= bus.job_target;
        res_q.id  <= bus.job_id;
        cnt       <= '0;
        stat_jobs <= stat_jobs + 32'd1;
      end else if (state == ISSUE || state == RUN) begin
        cnt <= cnt + 32'd1;
      end
      if (found_ev) begin
        res_q.nonce  <= bus.core_nonce;
        res_q.status <= ST_FOUND;
        stat_found   <= stat_found + 32'd1;
      end else if (abort_ev) begin
        res_q.nonce  <= '0;
        res_q.status <= ST_ABORT;
      end else if (tmo_ev) begin
        res_q.nonce  <= '0;
        res_q.status <= ST_TIMEOUT;
      end
    end
  end
endmodule

// File: tb/tb_siacore_sched.sv
// Directed and randomized checks of siacore_sched against a job-level outcome model.
module tb_siacore_sched;
  localparam logic [31:0] TMO  = 32'd16;
  localparam int          IDW  = 8;
  localparam int          NONE = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stat_jobs, stat_found;
  int          ncmp = 0, nfail = 0;
  logic [31:0] m_jobs = '0, m_found = '0;

  always #5 clk = ~clk;

  siacore_sched_if #(.ID_W(IDW)) bus ();

  siacore_sched #(.TIMEOUT(TMO), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stat_jobs(stat_jobs), .stat_found(stat_found)
  );

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    bus.job_valid  = 1'b0;
    bus.job_work   = '0;
    bus.job_target = '0;
    bus.job_id     = '0;
    bus.core_busy  = 1'b0;
    bus.core_found = 1'b0;
    bus.core_nonce = '0;
    bus.flush      = 1'b0;
    bus.res_ready  = 1'b0;
  endtask

  task automatic chk_reset_vals;
    chk("rst_core_valid", 640'(bus.core_valid), 640'(0));
    chk("rst_res_valid",  640'(bus.res_valid),  640'(0));
    chk("rst_res_nonce",  640'(bus.res_nonce),  640'(0));
    chk("rst_res_status", 640'(bus.res_status), 640'(0));
    chk("rst_res_id",     640'(bus.res_id),     640'(0));
    chk("rst_stat_jobs",  640'(stat_jobs),      640'(0));
    chk("rst_stat_found", 640'(stat_found),     640'(0));
    chk("rst_core_work",  bus.core_work,        640'(0));
  endtask

  // Outcome of a job from the cycle indices at which events occur. Index 0 is the first cycle
  // after accept. The core is busy on indices 1..be-1. The outcome is decided by the first index
  // that has a found, a flush or the last counted cycle. A found reports on the next cycle.
  // Otherwise the result reports one cycle after the first drain cycle on which busy is low.
  task automatic predict(input int f, input int fl, input int be, output int rep, output logic [1:0] st);
    int ev = -1;
    st = 2'd1;
    for (int i = 0; i < int'(TMO) && ev < 0; i++) begin
      if (i == f)                  begin ev = i; st = 2'd0; end
      else if (i == fl)            begin ev = i; st = 2'd2; end
      else if (i == int'(TMO) - 1) begin ev = i; st = 2'd1; end
    end
    if (st == 2'd0) rep = ev + 1;
    else            rep = ((ev + 1 > be) ? ev + 1 : be) + 1;
  endtask

  task automatic run_job(input logic [IDW-1:0] id, input int f, input int fl, input int be,
                         input int hold, input logic [31:0] nonce);
    logic [639:0] w;
    logic [63:0]  t;
    logic [1:0]   st;
    int           rep, idx;
    for (int k = 0; k < 20; k++) w[k*32 +: 32] = $urandom;
    t = {$urandom, $urandom};
    predict(f, fl, be, rep, st);
    bus.job_valid = 1'b1; bus.job_work = w; bus.job_target = t; bus.job_id = id;
    chk("job_ready_idle", 640'(bus.job_ready), 640'(1));
    tick;
    bus.job_valid = 1'b0;
    m_jobs = m_jobs + 32'd1;
    chk("core_valid_issue", 640'(bus.core_valid), 640'(1));
    chk("core_work",        bus.core_work,        w);
    chk("core_target",      640'(bus.core_target), 640'(t));
    idx = 0;
    while (!bus.res_valid && idx < 100) begin
      bus.core_busy  = (idx >= 1 && idx < be);
      bus.core_found = (idx == f);
      bus.core_nonce = (idx == f) ? nonce : $urandom;
      bus.flush      = (idx == fl);
      tick;
      idx++;
    end
    bus.core_busy = 1'b0; bus.core_found = 1'b0; bus.flush = 1'b0;
    if (st == 2'd0) m_found = m_found + 32'd1;
    chk("res_latency", 640'(idx),            640'(rep));
    chk("res_id",      640'(bus.res_id),     640'(id));
    chk("res_status",  640'(bus.res_status), 640'(st));
    chk("res_nonce",   640'(bus.res_nonce),  640'((st == 2'd0) ? nonce : 32'd0));
    chk("stat_jobs",   640'(stat_jobs),      640'(m_jobs));
    chk("stat_found",  640'(stat_found),     640'(m_found));
    for (int k = 0; k < hold; k++) begin
      bus.job_valid  = 1'b1;
      bus.flush      = 1'($urandom);
      bus.core_found = 1'($urandom);
      bus.core_nonce = $urandom;
      tick;
      chk("hold_res_valid", 640'(bus.res_valid),  640'(1));
      chk("hold_job_ready", 640'(bus.job_ready),  640'(0));
      chk("hold_status",    640'(bus.res_status), 640'(st));
      chk("hold_id",        640'(bus.res_id),     640'(id));
    end
    bus.job_valid = 1'b0; bus.flush = 1'b0; bus.core_found = 1'b0;
    bus.res_ready = 1'b1;
    tick;
    bus.res_ready = 1'b0;
    chk("post_job_ready",  640'(bus.job_ready),  640'(1));
    chk("post_res_valid",  640'(bus.res_valid),  640'(0));
    chk("post_core_valid", 640'(bus.core_valid), 640'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, fl;
    quiet();
    rst = 1'b1;
    tick; tick;
    chk_reset_vals();
    rst = 1'b0;
    tick;
    chk("job_ready_after_rst", 640'(bus.job_ready), 640'(1));

    run_job(8'h05, 4, NONE, 5, 0, 32'h1234ABCD);  // found after 3 busy cycles
    run_job(8'h11, NONE, NONE, 20, 0, 32'h0);     // timeout, busy drops at cycle 20
    run_job(8'h22, 6, 6, 10, 0, 32'hCAFEF00D);    // flush and found together
    run_job(8'h33, 9, 5, 12, 0, 32'hDEAD0001);    // abort, found during drain ignored
    run_job(8'h44, NONE, NONE, 0, 0, 32'h0);      // core never busy
    run_job(8'h55, 3, NONE, 5, 10, 32'h0BADBEEF); // result held for 10 cycles
    run_job(8'h01, 2, NONE, 4, 0, 32'h00000101);  // back-to-back ids 1, 2, 3
    run_job(8'h02, NONE, 3, 6, 0, 32'h0);
    run_job(8'h03, 5, NONE, 8, 0, 32'h00000303);

    for (int n = 0; n < 25; n++) begin
      f  = $urandom_range(0, 30); if (f > 22) f = NONE;
      fl = $urandom_range(0, 30); if (fl > 22) fl = NONE;
      run_job(8'($urandom), f, fl, $urandom_range(0, 25), $urandom_range(0, 2), $urandom);
    end

    // Reset while the job is running.
    bus.job_valid = 1'b1; bus.job_id = 8'h77; bus.job_work = '1;
    tick;
    bus.job_valid = 1'b0; bus.core_busy = 1'b1;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; bus.core_busy = 1'b0;
    m_jobs = '0; m_found = '0;
    chk_reset_vals();
    tick;
    chk("rst_run_no_result", 640'(bus.res_valid), 640'(0));
    run_job(8'h09, 2, NONE, 4, 0, 32'h99990000);

    // Reset while a result is pending.
    bus.job_valid = 1'b1; bus.job_id = 8'h66;
    tick;
    bus.job_valid = 1'b0; bus.core_found = 1'b1; bus.core_nonce = 32'h5;
    tick;
    bus.core_found = 1'b0;
    chk("pending_res_valid", 640'(bus.res_valid), 640'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_reset_vals();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
